paint_engine: RTL
=================

PAINT_ENGINE -- requirements
Module: paint_engine

Interface
REQ-001 Parameter SCREEN_W, 320, visible width in pixels.
REQ-002 Parameter SCREEN_H, 240, visible height in pixels.
REQ-003 Parameter X_BITS, 9, x coordinate width.
REQ-004 Parameter Y_BITS, 8, y coordinate width.
REQ-005 Parameter COLOR_BITS, 9, pixel colour width.
REQ-006 Parameter MAX_BRUSH, 8, largest square brush edge in pixels.
REQ-007 Parameter SIZE_BITS, 4, cmd_size width.
REQ-008 Parameter CURSOR_ARM, 10, cross-cursor half-length in pixels.
REQ-009 Parameter CURSOR_COLOR, 9'h1C0, cursor colour; BG_COLOR, 9'h000, colour used to erase the cursor.
REQ-010 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-011 resetn  in  1  reset, asynchronous, active-low.
REQ-012 cmd_valid  in  1  command offered; cmd_ready  out  1  engine can accept a command.
REQ-013 cmd_op  in  2  00 CLEAR, 01 MOVE, 10 STROKE, 11 REDRAW.
REQ-014 cmd_x / cmd_y  in  X_BITS / Y_BITS  command position; cmd_size  in  SIZE_BITS  brush edge; cmd_color  in  COLOR_BITS  fill/brush colour.
REQ-015 pix_valid  out  1  pixel write offered; pix_ready  in  1  sink accepts pixel.
REQ-016 pix_x / pix_y / pix_color  out  X_BITS / Y_BITS / COLOR_BITS  pixel write data.
REQ-017 busy  out  1  command in progress; cur_x / cur_y  out  X_BITS / Y_BITS  held cursor position.

Function
REQ-018 A command SHALL be accepted on a cycle with cmd_valid and cmd_ready high; cmd_ready SHALL equal (state == IDLE); all cmd_* fields SHALL be registered on acceptance.
REQ-019 FSM states SHALL be IDLE, CLEAR, ERASE_CUR, DRAW_CUR, BRUSH; IDLE->CLEAR (op 00), ->ERASE_CUR (01), ->BRUSH (10), ->DRAW_CUR (11); ERASE_CUR->DRAW_CUR; CLEAR, BRUSH, DRAW_CUR->IDLE after the last pixel transfers.
REQ-020 The first pixel SHALL be presented on pix_valid the cycle after acceptance; a pixel transfers when pix_valid and pix_ready are both high.
REQ-021 While pix_valid is high and pix_ready low, pix_x, pix_y, pix_color SHALL hold stable and the scan SHALL not advance.
REQ-022 CLEAR SHALL emit SCREEN_W*SCREEN_H pixels of cmd_color in row-major order (y outer, x inner) from (0,0) to (SCREEN_W-1,SCREEN_H-1).
REQ-023 STROKE SHALL emit an N x N square of cmd_color, top-left at (cmd_x,cmd_y), row-major, with N = 1 if cmd_size = 0, MAX_BRUSH if cmd_size > MAX_BRUSH, else cmd_size.
REQ-024 A cross SHALL be the horizontal arm x = cx-CURSOR_ARM..cx+CURSOR_ARM at cy, then the vertical arm y = cy-CURSOR_ARM..cy+CURSOR_ARM at cx skipping y = cy (4*CURSOR_ARM+1 pixels).
REQ-025 MOVE SHALL emit a BG_COLOR cross at the held cursor, then update cur_x/cur_y to cmd_x/cmd_y, then emit a CURSOR_COLOR cross there; REDRAW SHALL emit a CURSOR_COLOR cross at the held cursor.
REQ-026 MOVE SHALL clamp cmd_x to SCREEN_W-1 and cmd_y to SCREEN_H-1 before storing.
REQ-027 Offset coordinates SHALL be computed one bit wider and signed; any pixel with x < 0, x >= SCREEN_W, y < 0 or y >= SCREEN_H SHALL be clipped individually (scan advances one cycle, pix_valid low), never suppressing in-range pixels.
REQ-028 busy SHALL be high from the cycle after acceptance until the cycle after the final transfer; cmd_valid during busy SHALL be ignored (not queued).

Reset
REQ-029 On resetn low, state SHALL go to IDLE immediately, any scan SHALL abort with no further pixels, and pix_valid, busy SHALL be 0, cmd_ready 1.
REQ-030 Reset values: cur_x = SCREEN_W/2, cur_y = SCREEN_H/2, pix_x/pix_y/pix_color = 0, all counters 0.

Structure
REQ-031 Package paint_pkg SHALL hold the op-code constants, FSM state encoding and CURSOR_COLOR/BG_COLOR defaults.
REQ-032 A sub-module rect_scanner SHALL generate row/column counters with stall input and done output, used by CLEAR and BRUSH; the cross walk stays in paint_engine.
REQ-033 No divide or modulo operators SHALL be used for coordinate generation.

Verification
REQ-034 REDRAW after reset, pix_ready=1 -> 41 pixels CURSOR_COLOR, first (150,120), last (160,130), busy falls, cmd_ready 1.
REQ-035 MOVE to (200,100) from reset -> 41 BG_COLOR pixels centred (160,120) then 41 CURSOR_COLOR centred (200,100); cur_x=200, cur_y=100.
REQ-036 STROKE (318,239) size 3 colour 9'h1FF -> exactly 2 transfers, (318,239) and (319,239); size 0 -> 1 pixel; size 15 -> 64 pixels.
REQ-037 MOVE to (0,0) -> draw cross clipped to 21 pixels ((0..10,0) and (0,1..10)), no wrap-around coordinates.
REQ-038 CLEAR colour 0 with pix_ready toggled pseudo-randomly -> 76800 transfers, no duplicates, data stable under stall, last (319,239).
REQ-039 resetn low mid-CLEAR -> pix_valid 0 immediately, next REDRAW starts cleanly from (150,120).

Source files
------------

// File: rtl/paint_pkg.sv
// Shared op-codes, FSM state encoding and default colours for the paint engine.
package paint_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_MOVE   = 2'b01,
        OP_STROKE = 2'b10,
        OP_REDRAW = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ERASE_CUR,
        S_DRAW_CUR,
        S_BRUSH
    } state_e;

    localparam logic [8:0] DEF_CURSOR_COLOR = 9'h1C0;
    localparam logic [8:0] DEF_BG_COLOR     = 9'h000;

endpackage

// File: rtl/paint_engine_rect_scanner.sv
// Row-major rectangle walker: column inner, row outer, freezes while stall is high.
module rect_scanner #(
    parameter int unsigned COL_BITS = 9,
    parameter int unsigned ROW_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [COL_BITS-1:0] col_last,
    input  logic [ROW_BITS-1:0] row_last,
    input  logic                stall,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] row,
    output logic                done
);

    logic                run_q, run_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_last_q, col_last_d;
    logic [ROW_BITS-1:0] row_last_q, row_last_d;
    logic                at_end;

    assign at_end = (col_q == col_last_q) && (row_q == row_last_q);
    // done marks the cycle in which the final position is consumed
    assign done   = run_q && !stall && at_end;
    assign col    = col_q;
    assign row    = row_q;

    always_comb begin
        run_d      = run_q;
        col_d      = col_q;
        row_d      = row_q;
        col_last_d = col_last_q;
        row_last_d = row_last_q;
        if (start) begin
            run_d      = 1'b1;
            col_d      = '0;
            row_d      = '0;
            col_last_d = col_last;
            row_last_d = row_last;
        end else if (run_q && !stall) begin
            if (col_q == col_last_q) begin
                col_d = '0;
                if (row_q == row_last_q) begin
                    row_d = '0;
                    run_d = 1'b0;
                end else begin
                    row_d = row_q + ROW_BITS'(1);
                end
            end else begin
                col_d = col_q + COL_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            col_last_q <= '0;
            row_last_q <= '0;
        end else begin
            run_q      <= run_d;
            col_q      <= col_d;
            row_q      <= row_d;
            col_last_q <= col_last_d;
            row_last_q <= row_last_d;
        end
    end

endmodule

// File: rtl/paint_engine.sv
// Command-driven pixel writer: screen clear, square brush strokes and a cross cursor,
// streaming clipped pixel writes over a valid/ready interface.
module paint_engine
    import paint_pkg::*;
#(
    parameter int unsigned           SCREEN_W     = 320,
    parameter int unsigned           SCREEN_H     = 240,
    parameter int unsigned           X_BITS       = 9,
    parameter int unsigned           Y_BITS       = 8,
    parameter int unsigned           COLOR_BITS   = 9,
    parameter int unsigned           MAX_BRUSH    = 8,
    parameter int unsigned           SIZE_BITS    = 4,
    parameter int unsigned           CURSOR_ARM   = 10,
    parameter logic [COLOR_BITS-1:0] CURSOR_COLOR = DEF_CURSOR_COLOR,
    parameter logic [COLOR_BITS-1:0] BG_COLOR     = DEF_BG_COLOR
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [X_BITS-1:0]     cmd_x,
    input  logic [Y_BITS-1:0]     cmd_y,
    input  logic [SIZE_BITS-1:0]  cmd_size,
    input  logic [COLOR_BITS-1:0] cmd_color,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [X_BITS-1:0]     pix_x,
    output logic [Y_BITS-1:0]     pix_y,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  busy,
    output logic [X_BITS-1:0]     cur_x,
    output logic [Y_BITS-1:0]     cur_y
);

    localparam int unsigned XW = X_BITS + 1;
    localparam int unsigned YW = Y_BITS + 1;
    localparam int unsigned AW = $clog2(4 * CURSOR_ARM + 1);

    localparam logic [AW-1:0]        ARM_LAST  = AW'(4 * CURSOR_ARM);
    localparam logic [AW-1:0]        ARM_HLAST = AW'(2 * CURSOR_ARM);
    localparam logic [XW-1:0]        SW_X      = XW'(SCREEN_W);
    localparam logic [YW-1:0]        SH_Y      = YW'(SCREEN_H);
    localparam logic [X_BITS-1:0]    MAX_X     = X_BITS'(SCREEN_W - 1);
    localparam logic [Y_BITS-1:0]    MAX_Y     = Y_BITS'(SCREEN_H - 1);
    localparam logic [SIZE_BITS-1:0] MAX_N     = SIZE_BITS'(MAX_BRUSH);

    state_e                state_q, state_d;
    logic [AW-1:0]         arm_q, arm_d;
    logic [X_BITS-1:0]     cur_x_q, cur_x_d;
    logic [Y_BITS-1:0]     cur_y_q, cur_y_d;
    logic [X_BITS-1:0]     tgt_x_q, tgt_x_d;
    logic [Y_BITS-1:0]     tgt_y_q, tgt_y_d;
    logic [X_BITS-1:0]     org_x_q, org_x_d;
    logic [Y_BITS-1:0]     org_y_q, org_y_d;
    logic [COLOR_BITS-1:0] color_q, color_d;

    logic                  scan_start;
    logic                  scan_stall;
    logic                  scan_done;
    logic [X_BITS-1:0]     scan_col_last, scan_col;
    logic [Y_BITS-1:0]     scan_row_last, scan_row;
    logic [SIZE_BITS-1:0]  brush_n;

    logic [XW-1:0]         x_off;
    logic [YW-1:0]         y_off;
    logic [AW-1:0]         v_idx;
    logic                  pix_on;
    logic                  in_range;
    logic                  adv;
    logic [COLOR_BITS-1:0] pix_col;

    rect_scanner #(
        .COL_BITS (X_BITS),
        .ROW_BITS (Y_BITS)
    ) u_scan (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .start    (scan_start),
        .col_last (scan_col_last),
        .row_last (scan_row_last),
        .stall    (scan_stall),
        .col      (scan_col),
        .row      (scan_row),
        .done     (scan_done)
    );

    // Current pixel position, one bit wider so that the MSB acts as a sign bit.
    always_comb begin
        x_off   = '0;
        y_off   = '0;
        v_idx   = '0;
        pix_on  = 1'b0;
        pix_col = color_q;
        unique case (state_q)
            S_CLEAR, S_BRUSH: begin
                pix_on = 1'b1;
                x_off  = XW'(org_x_q) + XW'(scan_col);
                y_off  = YW'(org_y_q) + YW'(scan_row);
            end
            S_ERASE_CUR, S_DRAW_CUR: begin
                pix_on  = 1'b1;
                pix_col = (state_q == S_ERASE_CUR) ? BG_COLOR : CURSOR_COLOR;
                if (arm_q <= ARM_HLAST) begin
                    x_off = XW'(cur_x_q) + XW'(arm_q) - XW'(CURSOR_ARM);
                    y_off = YW'(cur_y_q);
                end else begin
                    // vertical arm skips the centre row already drawn by the horizontal arm
                    v_idx = arm_q - ARM_HLAST - AW'(1);
                    x_off = XW'(cur_x_q);
                    y_off = YW'(cur_y_q) + YW'(v_idx) - YW'(CURSOR_ARM)
                          + YW'(v_idx >= AW'(CURSOR_ARM));
                end
            end
            default: ;
        endcase
    end

    assign in_range   = !x_off[XW-1] && !y_off[YW-1] && (x_off < SW_X) && (y_off < SH_Y);
    assign adv        = pix_on && (!in_range || pix_ready);
    assign scan_stall = !adv;

    assign pix_valid = pix_on && in_range;
    assign pix_x     = pix_on ? x_off[X_BITS-1:0] : '0;
    assign pix_y     = pix_on ? y_off[Y_BITS-1:0] : '0;
    assign pix_color = pix_on ? pix_col : '0;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;

    always_comb begin
        state_d       = state_q;
        arm_d         = arm_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        tgt_x_d       = tgt_x_q;
        tgt_y_d       = tgt_y_q;
        org_x_d       = org_x_q;
        org_y_d       = org_y_q;
        color_d       = color_q;
        scan_start    = 1'b0;
        scan_col_last = '0;
        scan_row_last = '0;
        brush_n       = (cmd_size == '0) ? SIZE_BITS'(1)
                      : (cmd_size > MAX_N) ? MAX_N : cmd_size;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    color_d = cmd_color;
                    org_x_d = cmd_x;
                    org_y_d = cmd_y;
                    arm_d   = '0;
                    case (op_e'(cmd_op))
                        OP_CLEAR: begin
                            state_d       = S_CLEAR;
                            org_x_d       = '0;
                            org_y_d       = '0;
                            scan_start    = 1'b1;
                            scan_col_last = MAX_X;
                            scan_row_last = MAX_Y;
                        end
                        OP_MOVE: begin
                            state_d = S_ERASE_CUR;
                            tgt_x_d = (cmd_x > MAX_X) ? MAX_X : cmd_x;
                            tgt_y_d = (cmd_y > MAX_Y) ? MAX_Y : cmd_y;
                        end
                        OP_STROKE: begin
                            state_d       = S_BRUSH;
                            scan_start    = 1'b1;
                            scan_col_last = X_BITS'(brush_n - SIZE_BITS'(1));
                            scan_row_last = Y_BITS'(brush_n - SIZE_BITS'(1));
                        end
                        default: state_d = S_DRAW_CUR;
                    endcase
                end
            end
            S_CLEAR, S_BRUSH: begin
                if (scan_done) state_d = S_IDLE;
            end
            S_ERASE_CUR: begin
                if (adv) begin
                    if (arm_q == ARM_LAST) begin
                        arm_d   = '0;
                        cur_x_d = tgt_x_q;
                        cur_y_d = tgt_y_q;
                        state_d = S_DRAW_CUR;
                    end else begin
                        arm_d = arm_q + AW'(1);
                    end
                end
            end
            S_DRAW_CUR: begin
                if (adv) begin
                    if (arm_q == ARM_LAST) begin
                        arm_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        arm_d = arm_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            arm_q   <= '0;
            cur_x_q <= X_BITS'(SCREEN_W >> 1);
            cur_y_q <= Y_BITS'(SCREEN_H >> 1);
            tgt_x_q <= '0;
            tgt_y_q <= '0;
            org_x_q <= '0;
            org_y_q <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            org_x_q <= org_x_d;
            org_y_q <= org_y_d;
            color_q <= color_d;
        end
    end

endmodule
